// File: rtl/xgriscv_exmem_pkg.sv
// Shared constants and helpers for the EX->MEM stage: datapath width, funct3 codes
// and the access-size decode used by the store lane aligner.
package xgriscv_exmem_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  // Loads and stores share funct3 encodings but not the legal set, so decode separately.
  function automatic size_e access_size(input logic [2:0] funct3, input logic is_store);
    size_e sz;
    if (is_store) begin
      case (funct3)
        FUNCT3_SB: sz = SIZE_B;
        FUNCT3_SH: sz = SIZE_H;
        FUNCT3_SW: sz = SIZE_W;
        default:   sz = SIZE_X;
      endcase
    end else begin
      case (funct3)
        FUNCT3_LB, FUNCT3_LBU: sz = SIZE_B;
        FUNCT3_LH, FUNCT3_LHU: sz = SIZE_H;
        FUNCT3_LW:             sz = SIZE_W;
        default:               sz = SIZE_X;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] addr);
    logic mis;
    case (sz)
      SIZE_H:  mis = addr[0];
      SIZE_W:  mis = (addr != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/xgriscv_exmem_if.sv
// EX-side inputs and MEM-side outputs of the EX->MEM stage as one bundle.
interface xgriscv_exmem_if #(parameter int XLEN = 32);

  logic            ex_valid_i;
  logic [XLEN-1:0] ex_aluout_i;
  logic [XLEN-1:0] ex_pc_i;
  logic [XLEN-1:0] ex_imm_i;
  logic [XLEN-1:0] ex_rs2_i;
  logic            ex_branch_i;
  logic            ex_jal_i;
  logic            ex_jalr_i;
  logic            ex_memread_i;
  logic            ex_memwrite_i;
  logic [2:0]      ex_funct3_i;
  logic [4:0]      ex_rd_i;
  logic            ex_regwrite_i;

  logic            mem_valid_o;
  logic [XLEN-1:0] mem_result_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [3:0]      mem_be_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic [2:0]      mem_funct3_o;
  logic [4:0]      mem_rd_o;
  logic            mem_regwrite_o;
  logic            misalign_o;

  modport slave (
    input  ex_valid_i, ex_aluout_i, ex_pc_i, ex_imm_i, ex_rs2_i, ex_branch_i, ex_jal_i,
           ex_jalr_i, ex_memread_i, ex_memwrite_i, ex_funct3_i, ex_rd_i, ex_regwrite_i,
    output mem_valid_o, mem_result_o, mem_wdata_o, mem_be_o, mem_read_o, mem_write_o,
           mem_funct3_o, mem_rd_o, mem_regwrite_o, misalign_o
  );

  modport master (
    output ex_valid_i, ex_aluout_i, ex_pc_i, ex_imm_i, ex_rs2_i, ex_branch_i, ex_jal_i,
           ex_jalr_i, ex_memread_i, ex_memwrite_i, ex_funct3_i, ex_rd_i, ex_regwrite_i,
    input  mem_valid_o, mem_result_o, mem_wdata_o, mem_be_o, mem_read_o, mem_write_o,
           mem_funct3_o, mem_rd_o, mem_regwrite_o, misalign_o
  );

endinterface

// File: rtl/xgriscv_store_align.sv
// Combinational store lane aligner: byte enables, lane-replicated write data and
// misalignment flag from access size, low address bits and rs2.
module xgriscv_store_align
  import xgriscv_exmem_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rs2_i,
  input  logic        access_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  // Lane select and data replication per access size
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = rs2_i;
    case (size_i)
      SIZE_B: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{rs2_i[7:0]}};
      end
      SIZE_H: begin
        be_o    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_o = {2{rs2_i[15:0]}};
      end
      SIZE_W: begin
        be_o    = 4'b1111;
        wdata_o = rs2_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = rs2_i;
      end
    endcase
    if (access_i) begin
      misalign_o = is_misaligned(size_i, addr_i);
    end else begin
      misalign_o = 1'b0;
    end
  end

endmodule

// File: rtl/xgriscv_exmem.sv
// EX->MEM pipeline register with branch/jump redirect resolution and store lane alignment.
// redirect_o pulses once per taken instruction, however long the stage is stalled.
module xgriscv_exmem
  import xgriscv_exmem_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             flush_i,
  xgriscv_exmem_if.slave   bus,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o
);

  logic            valid_q;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] rs2_q;
  logic            read_q, write_q, regwrite_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            fired_q;

  logic            redirect_s;
  size_e           size_s;
  logic [3:0]      be_s;
  logic [31:0]     wdata_s;
  logic            mis_s;

  // Next-state values captured when the stage loads from EX
  always_comb begin
    taken_d = (bus.ex_branch_i & bus.ex_aluout_i[0]) | bus.ex_jal_i | bus.ex_jalr_i;
    if (bus.ex_jalr_i) begin
      target_d = {bus.ex_aluout_i[XLEN-1:1], 1'b0};
    end else begin
      target_d = bus.ex_pc_i + bus.ex_imm_i;
    end
    if (bus.ex_jal_i | bus.ex_jalr_i) begin
      result_d = bus.ex_pc_i + XLEN'(4);
    end else begin
      result_d = bus.ex_aluout_i;
    end
  end

  assign redirect_s = valid_q & taken_q & ~fired_q;

  // Pipeline register: flush beats stall beats load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      rs2_q      <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      regwrite_q <= 1'b0;
      funct3_q   <= 3'b000;
      rd_q       <= 5'd0;
      taken_q    <= 1'b0;
      target_q   <= RESET_PC;
      fired_q    <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      fired_q <= 1'b0;
    end else if (stall_i) begin
      if (redirect_s) begin
        fired_q <= 1'b1;
      end else begin
        fired_q <= fired_q;
      end
    end else begin
      valid_q    <= bus.ex_valid_i;
      result_q   <= result_d;
      rs2_q      <= bus.ex_rs2_i;
      read_q     <= bus.ex_memread_i;
      write_q    <= bus.ex_memwrite_i;
      regwrite_q <= bus.ex_regwrite_i;
      funct3_q   <= bus.ex_funct3_i;
      rd_q       <= bus.ex_rd_i;
      taken_q    <= taken_d;
      target_q   <= target_d;
      fired_q    <= 1'b0;
    end
  end

  assign size_s = access_size(funct3_q, write_q);

  xgriscv_store_align u_align (
    .size_i     (size_s),
    .addr_i     (result_q[1:0]),
    .rs2_i      (rs2_q[31:0]),
    .access_i   (read_q | write_q),
    .be_o       (be_s),
    .wdata_o    (wdata_s),
    .misalign_o (mis_s)
  );

  // Output strobes are only live for a valid, aligned access
  always_comb begin
    bus.mem_valid_o    = valid_q;
    bus.mem_result_o   = result_q;
    bus.mem_wdata_o    = XLEN'(wdata_s);
    bus.mem_funct3_o   = funct3_q;
    bus.mem_rd_o       = rd_q;
    redirect_o         = redirect_s;
    redirect_pc_o      = target_q;
    if (valid_q) begin
      bus.misalign_o     = mis_s;
      bus.mem_read_o     = read_q & ~mis_s;
      bus.mem_write_o    = write_q & ~mis_s;
      bus.mem_regwrite_o = regwrite_q & ~mis_s;
      if (write_q & ~mis_s) begin
        bus.mem_be_o = be_s;
      end else begin
        bus.mem_be_o = 4'b0000;
      end
    end else begin
      bus.misalign_o     = 1'b0;
      bus.mem_read_o     = 1'b0;
      bus.mem_write_o    = 1'b0;
      bus.mem_regwrite_o = 1'b0;
      bus.mem_be_o       = 4'b0000;
    end
  end

endmodule
